// File: rtl/updown_counter_fsm.sv
// updown_counter_fsm: loadable up/down counter with INC/INC2/DEC/DEC2/HOLD control FSM
// Ports: clk, reset (sync, active-high); i_en hold when 0; i_load loads i_d_in (beats i_inc);
//   i_inc up when 1 / down when 0; o_count, o_state, o_carry, o_borrow registered; o_zero = (o_count == 0).
// Build option: define CNT_SATURATE_EN to clamp at 2^WIDTH-1 / 0 instead of wrapping.
module updown_counter_fsm #(
  parameter int WIDTH = 8,
  parameter int STEP = 1,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_load,
  input  logic             i_inc,
  input  logic [WIDTH-1:0] i_d_in,
  output logic [WIDTH-1:0] o_count,
  output logic [2:0]       o_state,
  output logic             o_carry,
  output logic             o_borrow,
  output logic             o_zero
);
  typedef enum logic [2:0] {
    IDLE = 3'b000, LOAD = 3'b001, INC = 3'b010, INC2 = 3'b011,
    DEC = 3'b100, DEC2 = 3'b101, HOLD = 3'b110, ILL = 3'b111
  } state_t;
`ifdef CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_count, w_count;
  logic             r_carry, r_borrow, w_carry, w_borrow, w_up, w_dn;
  logic [WIDTH:0]   w_sum, w_diff;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= INIT;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_count  <= w_count;
      r_carry  <= w_carry;
      r_borrow <= w_borrow;
    end
  end
  // The extra MSB of sum/diff is the carry-out/borrow-out of the WIDTH-bit operation.
  always_comb begin
    w_next   = r_state == ILL ? IDLE :
               !i_en ? HOLD :
               i_load ? LOAD :
               i_inc ? (r_state == INC ? INC2 : INC) :
               (r_state == DEC ? DEC2 : DEC);
    w_up     = w_next == INC || w_next == INC2;
    w_dn     = w_next == DEC || w_next == DEC2;
    w_sum    = {1'b0, r_count} + STEP_X;
    w_diff   = {1'b0, r_count} - STEP_X;
    w_carry  = w_up && w_sum[WIDTH];
    w_borrow = w_dn && w_diff[WIDTH];
    w_count  = w_next == LOAD ? i_d_in :
               w_up ? (SAT && w_carry ? '1 : w_sum[WIDTH-1:0]) :
               w_dn ? (SAT && w_borrow ? '0 : w_diff[WIDTH-1:0]) :
               r_count;
  end
  assign o_count  = r_count;
  assign o_state  = r_state;
  assign o_carry  = r_carry;
  assign o_borrow = r_borrow;
  assign o_zero   = r_count == '0;
endmodule
